// File: rtl/mem_arb_pkg.sv
// Shared state encoding and default sizing for the CPU/host RAM arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HOST = 2'd1,
    S_ACK  = 2'd2
  } arb_state_t;

  localparam int MEM_ARB_ADDR_W       = 10;
  localparam int MEM_ARB_DATA_W       = 8;
  localparam int MEM_ARB_STARVE_LIMIT = 15;

endpackage

// File: rtl/mem_arb_starve_cnt.sv
// Saturating count of idle-state cycles in which a pending host request lost to the CPU.
// Only instantiated when MEM_ARB_STALL_EN is defined.
module mem_arb_starve_cnt
  import mem_arb_pkg::*;
#(
  parameter int LIMIT = MEM_ARB_STARVE_LIMIT,
  parameter int CNT_W = $clog2(LIMIT + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic at_limit;

  assign at_limit = (count == CNT_W'(LIMIT));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && !at_limit) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single-port program/data RAM between the CPU bus (always first) and a host port.
// Define MEM_ARB_STALL_EN to let a starved host request stall the CPU for one cycle.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = MEM_ARB_ADDR_W,
  parameter int DATA_W       = MEM_ARB_DATA_W,
  parameter int STARVE_LIMIT = MEM_ARB_STARVE_LIMIT
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cpu_mreq_n,
  input  logic              cpu_rd_n,
  input  logic              cpu_wr_n,
  input  logic [15:0]       cpu_addr,
  input  logic [DATA_W-1:0] cpu_dout,
  output logic [DATA_W-1:0] cpu_din,
  output logic              cpu_wait_n,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_ack,
  output logic [DATA_W-1:0] host_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_in,
  input  logic [DATA_W-1:0] mem_out
);

  arb_state_t state;
  logic       cpu_strb;
  logic       cpu_we;
  logic       go_host;

  assign cpu_strb = !cpu_mreq_n && (!cpu_rd_n || !cpu_wr_n);
  assign cpu_we   = !cpu_mreq_n && !cpu_wr_n;

  // The RAM only decodes the low address bits, so it mirrors across the CPU space.
  logic unused_addr_hi;
  assign unused_addr_hi = ^cpu_addr[15:ADDR_W];

`ifdef MEM_ARB_STALL_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  logic [CNT_W-1:0] starve_cnt;
  logic             starve_hit;
  logic             starve_clear;
  logic             starve_inc;

  assign starve_hit   = (starve_cnt == CNT_W'(STARVE_LIMIT));
  assign go_host      = (state == S_IDLE) && host_req && (!cpu_strb || starve_hit);
  assign starve_clear = !host_req || go_host;
  assign starve_inc   = (state == S_IDLE) && host_req && cpu_strb;

  mem_arb_starve_cnt #(
    .LIMIT (STARVE_LIMIT),
    .CNT_W (CNT_W)
  ) u_starve_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (starve_clear),
    .inc     (starve_inc),
    .count   (starve_cnt)
  );
`else
  logic [31:0] unused_limit;
  assign unused_limit = STARVE_LIMIT;
  assign go_host      = (state == S_IDLE) && host_req && !cpu_strb;
`endif

  // host_rdata captures in the ack cycle, when the RAM output reflects the host address.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      host_ack   <= 1'b0;
      host_rdata <= '0;
    end else begin
      host_ack <= 1'b0;
      case (state)
        S_IDLE: begin
          if (go_host) begin
            state <= S_HOST;
          end
        end
        S_HOST: begin
          state    <= S_ACK;
          host_ack <= 1'b1;
        end
        S_ACK: begin
          state      <= S_IDLE;
          host_rdata <= mem_out;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // A stalled CPU write never reaches the RAM because the host owns the port in S_HOST.
  always_comb begin
    mem_we   = cpu_we;
    mem_addr = cpu_addr[ADDR_W-1:0];
    mem_in   = cpu_dout;
    if (state == S_HOST) begin
      mem_we   = host_we;
      mem_addr = host_addr;
      mem_in   = host_wdata;
    end
    if (!reset_n) begin
      mem_we = 1'b0;
    end
  end

  assign cpu_wait_n = !((state == S_HOST) && cpu_strb);
  assign cpu_din    = mem_out;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter for the single-port on-chip program/data RAM shared by the tv80n CPU bus and a host port (serial loader / debug access). The CPU has priority on every cycle. Host transfers use idle memory cycles, or, when the stall feature is compiled in, steal a cycle by pulling `cpu_wait_n` low. The block sits between the CPU bus signals and the `memory` instance, replacing the direct CPU-to-RAM wiring in the system top.

## Interface
Parameters:
- `ADDR_W`, 10: RAM address width. The CPU address is decoded on bits `[ADDR_W-1:0]` only, so the RAM mirrors across the 64 KB space.
- `DATA_W`, 8: data width.
- `STARVE_LIMIT`, 15: number of cycles a host request may wait before a forced stall. Used only with `MEM_ARB_STALL_EN`.

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `cpu_mreq_n`, `cpu_rd_n`, `cpu_wr_n`  in  1  CPU bus strobes.
- `cpu_addr`  in  16  CPU address.
- `cpu_dout`  in  DATA_W  CPU write data.
- `cpu_din`  out  DATA_W  read data to the CPU, equal to `mem_out`.
- `cpu_wait_n`  out  1  CPU stall, active low.
- `host_req`  in  1  host request, level.
- `host_we`  in  1  host request is a write.
- `host_addr`  in  ADDR_W  host address.
- `host_wdata`  in  DATA_W  host write data.
- `host_ack`  out  1  one-cycle completion pulse.
- `host_rdata`  out  DATA_W  registered host read data.
- `mem_we`, `mem_addr`, `mem_in`  out  1/ADDR_W/DATA_W  RAM controls.
- `mem_out`  in  DATA_W  RAM read data; 1-cycle registered latency.

## Operation
- CPU strobe: `cpu_strb = !cpu_mreq_n && (!cpu_rd_n || !cpu_wr_n)`.
- The FSM has three states: `S_IDLE` (CPU granted), `S_HOST` (host granted), `S_ACK` (CPU granted, ack pulse).
- Transitions:
  - `S_IDLE -> S_HOST` when `host_req && !cpu_strb`. With the stall feature, also when `host_req && starve_cnt == STARVE_LIMIT`.
  - `S_HOST -> S_ACK` always.
  - `S_ACK -> S_IDLE` always.
- In `S_IDLE` and `S_ACK` the RAM is driven from the CPU:
  - `mem_we = !cpu_mreq_n && !cpu_wr_n`
  - `mem_addr = cpu_addr[ADDR_W-1:0]`
  - `mem_in = cpu_dout`
- In `S_HOST` the RAM is driven from the host:
  - `mem_we = host_we`
  - `mem_addr = host_addr`
  - `mem_in = host_wdata`
- `cpu_wait_n = !(state == S_HOST && cpu_strb)`. This is combinational. A CPU write is never issued to RAM while stalled.
- In `S_ACK`:
  - `host_ack` is 1 and `host_rdata` is loaded from `mem_out`, which holds the host-address data. The load happens for writes too; the value is then the pre-write content.
  - `host_req` is ignored.
- The requester drops `host_req` in the ack cycle. If `host_req` is still high in the next `S_IDLE` cycle, a new transfer starts.
- Host inputs must stay stable from the assertion of `host_req` until `host_ack`.

## Timing
- Reset values: state `S_IDLE`, `host_ack` 0, `host_rdata` 0, `cpu_wait_n` 1, `starve_cnt` 0.
- `mem_we` is forced to 0 while `reset_n` is low.
- Host latency, measured from the `S_IDLE` cycle in which `host_req` is seen while the CPU is idle:
  - `S_HOST` is the next cycle.
  - `host_ack` is high in the cycle after that.
  - Ack arrives 2 cycles after `host_req` is seen, with 3 cycles minimum per transfer.
- Simultaneous `cpu_strb` and `host_req` in `S_IDLE`: the CPU wins and the host stays pending.
- A CPU strobe starting during `S_HOST` is stalled for exactly 1 cycle.
- Reset asserted mid-transfer: the transfer is aborted, no ack is issued, and no RAM write occurs.

## Configuration
- `MEM_ARB_STALL_EN` defined:
  - `starve_cnt` (width `$clog2(STARVE_LIMIT+1)`) increments, saturating, in `S_IDLE` while `host_req && cpu_strb`.
  - It clears on entry to `S_HOST` and whenever `host_req` is 0.
  - At `STARVE_LIMIT` the FSM enters `S_HOST` even with `cpu_strb` active, so `cpu_wait_n` is low for 1 cycle.
- `MEM_ARB_STALL_EN` undefined: no counter is built. The host is served only on CPU-idle cycles and may starve indefinitely.

## Structure
- Package `mem_arb_pkg` holds:
  - the state enum `arb_state_t` (`S_IDLE`=2'd0, `S_HOST`=2'd1, `S_ACK`=2'd2);
  - default constants `MEM_ARB_ADDR_W` = 10, `MEM_ARB_DATA_W` = 8, `MEM_ARB_STARVE_LIMIT` = 15.
- Sub-module `mem_arb_starve_cnt` is the saturating counter, instantiated only under `MEM_ARB_STALL_EN`.
- All remaining logic is flat: the FSM, the RAM mux and the `host_rdata` register.

## Test plan
- Host write `0x3A5 <= 0x5A` with the CPU idle, then a host read of `0x3A5`:
  - each ack arrives 2 cycles after `host_req` is seen;
  - the read returns `host_rdata = 0x5A`.
- CPU write of `0x77` to `0x0010` in the same cycle as a host read request for `0x010`:
  - `mem_we` comes from the CPU;
  - the host is served after the strobe ends and returns `0x77`.
- CPU read at `0x0410` after a host write of `0xC3` to `0x010`: `cpu_din = 0xC3`, showing the mirror.
- Starvation with `STARVE_LIMIT=4`:
  - CPU holds a continuous read strobe with `host_req` high.
  - With the macro: after 4 cycles `cpu_wait_n` is 0 for exactly 1 cycle, and `host_ack` follows.
  - Without the macro: no ack, and `cpu_wait_n` stays 1.
- Reset asserted during `S_HOST` with `host_we=1`, `host_addr=0x100`:
  - no ack, `mem_we` stays 0, and all outputs go to their reset values;
  - a later read of `0x100` returns the old contents.
- `host_req` held high across an ack: the second transfer acks exactly 3 cycles after the first.
